// File: rtl/serdes_pkg.sv
// serdes_pkg
//   Framing definitions shared by the serial link endpoints (Serializer and
//   deserializer), so both ends agree on state encoding and line levels.
//   Contents:
//     rx_state_t  receiver FSM states (IDLE, SHIFT, STOP)
//     START_BIT   line level that opens a frame
//     STOP_BIT    line level that must close a frame when a stop bit is used
//     LINE_IDLE   line level between frames
package serdes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2
  } rx_state_t;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;
  localparam logic LINE_IDLE = 1'b0;

endpackage

// File: rtl/sipo_shift_reg.sv
// sipo_shift_reg
//   Serial-in / parallel-out shift register. Each enabled clock shifts din
//   into the LSB, so the first bit received ends up in the MSB after SIZE
//   shifts (MSB-first framing).
//   Ports:
//     clk       clock, all logic on posedge
//     reset     synchronous, active-low clear
//     shift_en  shift din in this cycle
//     din       serial input bit
//     q         parallel contents, MSB = oldest bit
module sipo_shift_reg #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            shift_en,
  input  logic            din,
  output logic [SIZE-1:0] q
);

  // Shift towards the MSB so the earliest bit of the frame lands on top.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[SIZE-2:0], din};
    end
  end

endmodule

// File: rtl/deserializer.sv
// deserializer
//   Serial-to-parallel receiver for a one-bit line. Waits for a start bit,
//   shifts in SIZE data bits MSB first, optionally checks a trailing stop
//   bit, and presents the word on data_out with a valid/ack handshake.
//   Parameters:
//     SIZE        data bits per frame (>= 2)
//     STOP_CHECK  1: frame ends with a stop bit that must be 0; 0: no stop bit
//   Ports:
//     clk             clock, all logic on posedge
//     reset           synchronous, active-low
//     serial_data_in  serial line, idles at 0
//     data_ack        consumer takes data_out this cycle (only while valid)
//     data_out        last accepted word
//     valid           data_out holds an unconsumed word
//     busy            a frame is in progress
//     frame_error     one-cycle pulse when the stop bit is sampled as 1
//     overrun         sticky flag: a completed word was dropped
module deserializer
  import serdes_pkg::*;
#(
  parameter int SIZE       = 32,
  parameter int STOP_CHECK = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            serial_data_in,
  input  logic            data_ack,
  output logic [SIZE-1:0] data_out,
  output logic            valid,
  output logic            busy,
  output logic            frame_error,
  output logic            overrun
);

  localparam int CW = $clog2(SIZE + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(SIZE - 1);

  rx_state_t       state;
  rx_state_t       state_next;
  logic [CW-1:0]   counter;
  logic [CW-1:0]   counter_next;
  logic [SIZE-1:0] sreg_q;
  logic [SIZE-1:0] word;
  logic            shift_en;
  logic            complete;
  logic            frame_err_next;

  assign shift_en = (state == SHIFT);

  sipo_shift_reg #(
    .SIZE (SIZE)
  ) u_sipo (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .din      (serial_data_in),
    .q        (sreg_q)
  );

  // Without a stop bit the word completes on the same edge that samples the
  // last data bit, so that bit is still on the line and must be spliced in.
  // With a stop bit the register already holds the whole word.
  assign word = (STOP_CHECK != 0) ? sreg_q : {sreg_q[SIZE-2:0], serial_data_in};

  // Next-state logic. A 1 seen in STOP is a framing error, not a new start
  // bit, so STOP always returns to IDLE.
  always_comb begin
    state_next     = state;
    counter_next   = counter;
    complete       = 1'b0;
    frame_err_next = 1'b0;
    case (state)
      IDLE: begin
        if (serial_data_in == START_BIT) begin
          state_next   = SHIFT;
          counter_next = '0;
        end
      end
      SHIFT: begin
        counter_next = counter + 1'b1;
        if (counter == LAST_BIT) begin
          if (STOP_CHECK != 0) begin
            state_next = STOP;
          end else begin
            state_next = IDLE;
            complete   = 1'b1;
          end
        end
      end
      STOP: begin
        state_next = IDLE;
        if (serial_data_in == STOP_BIT) begin
          complete = 1'b1;
        end else begin
          frame_err_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, status and handshake registers. A completing word wins over an
  // acknowledge on the same edge (valid stays high with the new word); a
  // word completing while the previous one is still unacknowledged is
  // dropped and flagged through overrun until the consumer acknowledges.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      counter     <= '0;
      data_out    <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_next;
      counter     <= counter_next;
      busy        <= (state_next != IDLE);
      frame_error <= frame_err_next;

      if (complete && (!valid || data_ack)) begin
        data_out <= word;
        valid    <= 1'b1;
      end else if (valid && data_ack) begin
        valid <= 1'b0;
      end

      if (data_ack) begin
        overrun <= 1'b0;
      end else if (complete && valid) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer
//   Testbench for deserializer with SIZE=8. Two instances: one with a stop
//   bit (dut1) and one without (dut0). Directed handshake, error and reset
//   scenarios run on dut1 with a manually driven ack; randomized frames run
//   with an auto-acking monitor that pops expected words and arrival cycles
//   from a scoreboard queue.
module tb_deserializer;

  localparam int SIZE = 8;

  typedef struct {
    logic [SIZE-1:0] w;
    int              cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  int              cycle = 0;
  int              checks = 0;
  int              failures = 0;

  // dut1: STOP_CHECK=1
  logic            sdi1 = 1'b0;
  logic            man_ack1 = 1'b0;
  logic            mon_ack1 = 1'b0;
  bit              auto_ack1 = 1'b0;
  logic            ack1;
  logic [SIZE-1:0] data1;
  logic            valid1, busy1, fe1, ov1;
  int              fe_count1 = 0;
  exp_t            q1[$];

  // dut0: STOP_CHECK=0
  logic            sdi0 = 1'b0;
  logic            mon_ack0 = 1'b0;
  logic [SIZE-1:0] data0;
  logic            valid0, busy0, fe0, ov0;
  exp_t            q0[$];

  assign ack1 = auto_ack1 ? mon_ack1 : man_ack1;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  deserializer #(.SIZE(SIZE), .STOP_CHECK(1)) dut1 (
    .clk            (clk),
    .reset          (reset),
    .serial_data_in (sdi1),
    .data_ack       (ack1),
    .data_out       (data1),
    .valid          (valid1),
    .busy           (busy1),
    .frame_error    (fe1),
    .overrun        (ov1)
  );

  deserializer #(.SIZE(SIZE), .STOP_CHECK(0)) dut0 (
    .clk            (clk),
    .reset          (reset),
    .serial_data_in (sdi0),
    .data_ack       (mon_ack0),
    .data_out       (data0),
    .valid          (valid0),
    .busy           (busy0),
    .frame_error    (fe0),
    .overrun        (ov0)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Drive one Serializer-compatible frame: start bit, data MSB first, then
  // the stop bit when with_stop is set. Called #1 after a posedge; returns
  // #1 after the edge that sampled the final bit. t_start is the cycle
  // number of the edge that sampled the start bit.
  task automatic applyStimulus(input int which, input logic [SIZE-1:0] w,
                               input bit with_stop, input logic stop_val,
                               output int t_start);
    if (which == 1) sdi1 = 1'b1; else sdi0 = 1'b1;
    @(posedge clk); #1;
    t_start = cycle;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (which == 1) sdi1 = w[i]; else sdi0 = w[i];
      @(posedge clk); #1;
    end
    if (with_stop) begin
      if (which == 1) sdi1 = stop_val; else sdi0 = stop_val;
      @(posedge clk); #1;
    end
    if (which == 1) sdi1 = 1'b0; else sdi0 = 1'b0;
  endtask

  task automatic pulseAck1();
    man_ack1 = 1'b1;
    @(posedge clk); #1;
    man_ack1 = 1'b0;
  endtask

  // Frame-error pulses on dut1, counted once per cycle they are high.
  always @(negedge clk) if (fe1) fe_count1++;

  // Monitor for dut1 in auto-ack mode: every presented word is compared to
  // the scoreboard head (value and arrival cycle) and acknowledged at once.
  always @(negedge clk) begin
    if (auto_ack1) begin
      if (valid1) begin
        if (q1.size() == 0) begin
          checkOutput("dut1_spurious_valid", 32'(valid1), 32'd0);
        end else begin
          exp_t e;
          e = q1.pop_front();
          checkOutput("dut1_word", 32'(data1), 32'(e.w));
          checkOutput("dut1_arrival_cycle", cycle, e.cyc);
          checkOutput("dut1_overrun", 32'(ov1), 32'd0);
        end
        mon_ack1 = 1'b1;
      end else begin
        mon_ack1 = 1'b0;
      end
    end
  end

  // Monitor for dut0, always auto-acking.
  always @(negedge clk) begin
    if (reset) begin
      if (valid0) begin
        if (q0.size() == 0) begin
          checkOutput("dut0_spurious_valid", 32'(valid0), 32'd0);
        end else begin
          exp_t e;
          e = q0.pop_front();
          checkOutput("dut0_word", 32'(data0), 32'(e.w));
          checkOutput("dut0_arrival_cycle", cycle, e.cyc);
        end
        mon_ack0 = 1'b1;
      end else begin
        mon_ack0 = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t, t2, fe_before, exp_fe, gap;
    logic [SIZE-1:0] w;
    bit bad;
    exp_t e;

    // Reset
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(valid1), 32'd0);
    checkOutput("reset_data", 32'(data1), 32'd0);
    checkOutput("reset_busy", 32'(busy1), 32'd0);
    checkOutput("reset_overrun", 32'(ov1), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: single frame, no ack, then ack
    $display("[TB] test 1: single frame 0xA5");
    applyStimulus(1, 8'hA5, 1'b1, 1'b0, t);
    checkOutput("t1_valid", 32'(valid1), 32'd1);
    checkOutput("t1_data", 32'(data1), 32'hA5);
    checkOutput("t1_frame_error", 32'(fe1), 32'd0);
    checkOutput("t1_overrun", 32'(ov1), 32'd0);
    checkOutput("t1_busy", 32'(busy1), 32'd0);
    pulseAck1();
    checkOutput("t1_valid_after_ack", 32'(valid1), 32'd0);

    // 3: bad stop bit, then a good frame
    $display("[TB] test 3: frame error then 0x81");
    fe_before = fe_count1;
    applyStimulus(1, 8'h5A, 1'b1, 1'b1, t);
    checkOutput("t3_frame_error", 32'(fe1), 32'd1);
    checkOutput("t3_valid", 32'(valid1), 32'd0);
    checkOutput("t3_busy", 32'(busy1), 32'd0);
    @(posedge clk); #1;
    checkOutput("t3_frame_error_cleared", 32'(fe1), 32'd0);
    applyStimulus(1, 8'h81, 1'b1, 1'b0, t);
    checkOutput("t3_pulse_width", fe_count1 - fe_before, 1);
    checkOutput("t3_valid2", 32'(valid1), 32'd1);
    checkOutput("t3_data2", 32'(data1), 32'h81);
    pulseAck1();

    // 4: overrun
    $display("[TB] test 4: overrun");
    applyStimulus(1, 8'h11, 1'b1, 1'b0, t);
    applyStimulus(1, 8'h22, 1'b1, 1'b0, t);
    checkOutput("t4_data", 32'(data1), 32'h11);
    checkOutput("t4_valid", 32'(valid1), 32'd1);
    checkOutput("t4_overrun", 32'(ov1), 32'd1);
    pulseAck1();
    checkOutput("t4_valid_after_ack", 32'(valid1), 32'd0);
    checkOutput("t4_overrun_after_ack", 32'(ov1), 32'd0);

    // 5: reset mid-frame with a word pending
    $display("[TB] test 5: reset mid-frame");
    applyStimulus(1, 8'h33, 1'b1, 1'b0, t);
    sdi1 = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("t5_busy_before_reset", 32'(busy1), 32'd1);
    reset = 1'b0;
    sdi1 = 1'b0;
    @(posedge clk); #1;
    checkOutput("t5_valid", 32'(valid1), 32'd0);
    checkOutput("t5_data", 32'(data1), 32'd0);
    checkOutput("t5_busy", 32'(busy1), 32'd0);
    checkOutput("t5_overrun", 32'(ov1), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    applyStimulus(1, 8'h0F, 1'b1, 1'b0, t);
    checkOutput("t5_new_valid", 32'(valid1), 32'd1);
    checkOutput("t5_new_data", 32'(data1), 32'h0F);
    pulseAck1();

    // 2 and randomized frames on dut1 through the scoreboard
    $display("[TB] test 2: back-to-back frames and random traffic");
    auto_ack1 = 1'b1;
    applyStimulus(1, 8'h3C, 1'b1, 1'b0, t);
    e.w = 8'h3C; e.cyc = t + SIZE + 1; q1.push_back(e);
    applyStimulus(1, 8'hC3, 1'b1, 1'b0, t2);
    e.w = 8'hC3; e.cyc = t2 + SIZE + 1; q1.push_back(e);
    checkOutput("t2_spacing", t2 - t, SIZE + 2);

    fe_before = fe_count1;
    exp_fe = 0;
    for (int n = 0; n < 30; n++) begin
      gap = int'($urandom_range(0, 3));
      repeat (gap) begin
        @(posedge clk); #1;
      end
      w = SIZE'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      applyStimulus(1, w, 1'b1, bad, t);
      if (bad) begin
        exp_fe++;
      end else begin
        e.w = w; e.cyc = t + SIZE + 1; q1.push_back(e);
      end
    end
    for (int k = 0; k < 20 && q1.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    checkOutput("rand_queue1_drained", q1.size(), 0);
    checkOutput("rand_frame_errors", fe_count1 - fe_before, exp_fe);
    checkOutput("rand_overrun", 32'(ov1), 32'd0);

    // 6: no stop bit, long idle, then frames
    $display("[TB] test 6: STOP_CHECK=0");
    repeat (20) begin
      @(posedge clk); #1;
    end
    checkOutput("t6_idle_valid", 32'(valid0), 32'd0);
    checkOutput("t6_idle_busy", 32'(busy0), 32'd0);
    applyStimulus(0, 8'h80, 1'b0, 1'b0, t);
    e.w = 8'h80; e.cyc = t + SIZE; q0.push_back(e);
    for (int n = 0; n < 15; n++) begin
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin
        @(posedge clk); #1;
      end
      w = SIZE'($urandom);
      applyStimulus(0, w, 1'b0, 1'b0, t);
      e.w = w; e.cyc = t + SIZE; q0.push_back(e);
    end
    for (int k = 0; k < 20 && q0.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    checkOutput("t6_queue0_drained", q0.size(), 0);
    checkOutput("t6_frame_error", 32'(fe0), 32'd0);
    checkOutput("t6_overrun", 32'(ov0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
